// File: rtl/video_layer_compositor_if.sv
// video_layer_compositor_if: timing, layer pixel, config and DAC-side signals of the layer compositor.
interface video_layer_compositor_if #(
   parameter int NUM_LAYERS  = 2,
   parameter int COLOR_W     = 4,
   parameter int FRAME_CNT_W = 8
);
   logic                            hsync_in;
   logic                            vsync_in;
   logic                            display_active_in;
   logic [9:0]                      hcount;
   logic [9:0]                      vcount;
   logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb;
   logic [NUM_LAYERS-1:0]           layer_valid;
   logic                            cfg_wr;
   logic [NUM_LAYERS-1:0]           cfg_enable;
   logic [3*COLOR_W-1:0]            cfg_backdrop;
   logic                            cfg_pending;
   logic [COLOR_W-1:0]              red;
   logic [COLOR_W-1:0]              green;
   logic [COLOR_W-1:0]              blue;
   logic                            hsync;
   logic                            vsync;
   logic                            frame_start;
   logic [FRAME_CNT_W-1:0]          frame_count;
   modport master (
      output hsync_in, vsync_in, display_active_in, hcount, vcount, layer_rgb, layer_valid,
             cfg_wr, cfg_enable, cfg_backdrop,
      input  cfg_pending, red, green, blue, hsync, vsync, frame_start, frame_count
   );
   modport slave (
      input  hsync_in, vsync_in, display_active_in, hcount, vcount, layer_rgb, layer_valid,
             cfg_wr, cfg_enable, cfg_backdrop,
      output cfg_pending, red, green, blue, hsync, vsync, frame_start, frame_count
   );
endinterface

// File: rtl/video_layer_compositor.sv
// video_layer_compositor: priority composite of renderer layers with frame-synchronous config commit.
// Define VGA_BORDER_DEBUG_EN to paint the visible-area border all-ones.
module video_layer_compositor #(
   parameter int                    NUM_LAYERS      = 2,
   parameter int                    COLOR_W         = 4,
   parameter int                    PIPE_DEPTH      = 2,
   parameter bit                    SYNC_ACTIVE_LOW = 1,
   parameter int                    FRAME_CNT_W     = 8,
   parameter logic [NUM_LAYERS-1:0] RESET_ENABLE    = 1
) (
   input logic                     clk_25mhz,
   input logic                     reset_n,
   video_layer_compositor_if.slave bus
);
   localparam int   PW    = 3*COLOR_W;
   localparam logic S_ACT = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
`ifdef VGA_BORDER_DEBUG_EN
   localparam int TW = 23;
`else
   localparam int TW = 3;
`endif
   logic [TW-1:0]         t_in, t_rst, a_t;
   logic                  a_hs, a_vs, a_da, boundary;
   logic [NUM_LAYERS-1:0] en_act, en_sh;
   logic [PW-1:0]         bd_act, bd_sh, pix;
`ifdef VGA_BORDER_DEBUG_EN
   logic [9:0]            a_hc, a_vc;
   assign t_in = {bus.vcount, bus.hcount, bus.display_active_in, bus.vsync_in, bus.hsync_in};
   assign a_hc = a_t[12:3];
   assign a_vc = a_t[22:13];
`else
   logic                  unused_cnt;
   assign t_in       = {bus.display_active_in, bus.vsync_in, bus.hsync_in};
   assign unused_cnt = ^{bus.hcount, bus.vcount};
`endif
   assign t_rst = TW'({1'b0, ~S_ACT, ~S_ACT});
   generate
      if (PIPE_DEPTH == 0) begin : g_nodly
         assign a_t = t_in;
      end else begin : g_dly
         logic [TW-1:0] sr [PIPE_DEPTH];
         always_ff @(posedge clk_25mhz or negedge reset_n)
            if (!reset_n)
               for (int k = 0; k < PIPE_DEPTH; k++) sr[k] <= t_rst;
            else begin
               sr[0] <= t_in;
               for (int k = 1; k < PIPE_DEPTH; k++) sr[k] <= sr[k-1];
            end
         assign a_t = sr[PIPE_DEPTH-1];
      end
   endgenerate
   assign a_hs = a_t[0];
   assign a_vs = a_t[1];
   assign a_da = a_t[2];
   // registered vsync holds the previous aligned vsync, so it doubles as the edge detector
   assign boundary = (a_vs == S_ACT) && (bus.vsync != S_ACT);
   always_comb begin
      pix = bd_act;
      for (int i = 0; i < NUM_LAYERS; i++)
         if (bus.layer_valid[i] && en_act[i]) pix = bus.layer_rgb[i*PW +: PW];
`ifdef VGA_BORDER_DEBUG_EN
      if (a_hc == 10'd0 || a_hc == 10'd639 || a_vc == 10'd0 || a_vc == 10'd479) pix = '1;
`endif
      if (!a_da) pix = '0;
   end
   always_ff @(posedge clk_25mhz or negedge reset_n)
      if (!reset_n) begin
         {bus.red, bus.green, bus.blue} <= '0;
         bus.hsync                      <= ~S_ACT;
         bus.vsync                      <= ~S_ACT;
         bus.frame_start                <= 1'b0;
         bus.frame_count                <= '0;
         bus.cfg_pending                <= 1'b0;
         en_act                         <= RESET_ENABLE;
         en_sh                          <= RESET_ENABLE;
         bd_act                         <= '0;
         bd_sh                          <= '0;
      end else begin
         {bus.red, bus.green, bus.blue} <= pix;
         bus.hsync                      <= a_hs;
         bus.vsync                      <= a_vs;
         bus.frame_start                <= boundary;
         if (boundary) bus.frame_count <= bus.frame_count + 1'b1;
         if (boundary && bus.cfg_pending) {en_act, bd_act} <= {en_sh, bd_sh};
         if (bus.cfg_wr) {en_sh, bd_sh} <= {bus.cfg_enable, bus.cfg_backdrop};
         // a write on the commit cycle keeps pending set so it lands next frame
         bus.cfg_pending <= bus.cfg_wr || (bus.cfg_pending && !boundary);
      end
endmodule

// File: tb/tb_video_layer_compositor.sv
// tb_video_layer_compositor: randomized frames checked against a queue-based reference model.
module tb_video_layer_compositor;
   localparam int NL = 2, CW = 4, PD = 2, FCW = 8;
   localparam int PW = 3*CW, LINE = 16, LINES = 8;
   logic clk = 1'b0, reset_n = 1'b0;
   int   n_checks = 0, n_fail = 0;
   video_layer_compositor_if #(.NUM_LAYERS(NL), .COLOR_W(CW), .FRAME_CNT_W(FCW)) bus();
   video_layer_compositor #(
      .NUM_LAYERS(NL), .COLOR_W(CW), .PIPE_DEPTH(PD), .SYNC_ACTIVE_LOW(1),
      .FRAME_CNT_W(FCW), .RESET_ENABLE(2'b01)
   ) dut (
      .clk_25mhz(clk),
      .reset_n(reset_n),
      .bus(bus)
   );
   always #20 clk = ~clk;
   // model: timing samples wait PD cycles in a queue; config applied at vsync falling edges
   logic [2:0]    m_q[$];
   logic          m_prev_vs_act, m_pend;
   logic [NL-1:0] m_en, m_en_sh;
   logic [PW-1:0] m_bd, m_bd_sh, e_rgb;
   logic          e_hs, e_vs, e_fs;
   int            m_frames;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask
   task automatic model_reset();
      m_q.delete();
      for (int i = 0; i < PD; i++) m_q.push_back(3'b011);
      m_prev_vs_act = 1'b0;
      m_en = 2'b01; m_en_sh = 2'b01; m_bd = '0; m_bd_sh = '0; m_pend = 1'b0; m_frames = 0;
      e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
   endtask
   task automatic model_edge();
      logic [2:0]    a;
      logic          bnd;
      logic [PW-1:0] p;
      m_q.push_back({bus.display_active_in, bus.vsync_in, bus.hsync_in});
      a   = m_q.pop_front();
      bnd = !a[1] && !m_prev_vs_act;
      p   = m_bd;
      for (int i = NL-1; i >= 0; i--)
         if (bus.layer_valid[i] && m_en[i]) begin
            p = bus.layer_rgb[i*PW +: PW];
            break;
         end
      e_rgb = a[2] ? p : '0;
      e_hs = a[0]; e_vs = a[1]; e_fs = bnd;
      m_prev_vs_act = !a[1];
      if (bnd) begin
         m_frames++;
         if (m_pend) begin m_en = m_en_sh; m_bd = m_bd_sh; m_pend = 1'b0; end
      end
      if (bus.cfg_wr) begin m_en_sh = bus.cfg_enable; m_bd_sh = bus.cfg_backdrop; m_pend = 1'b1; end
   endtask
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("rgb", 32'({bus.red, bus.green, bus.blue}), 32'(e_rgb));
      check("hsync", 32'(bus.hsync), 32'(e_hs));
      check("vsync", 32'(bus.vsync), 32'(e_vs));
      check("frame_start", 32'(bus.frame_start), 32'(e_fs));
      check("frame_count", 32'(bus.frame_count), 32'(m_frames % (1 << FCW)));
      check("cfg_pending", 32'(bus.cfg_pending), 32'(m_pend));
   endtask
   task automatic hold(input logic [NL-1:0] v, input logic [NL*PW-1:0] rgb, input int n);
      bus.hsync_in = 1'b1; bus.vsync_in = 1'b1; bus.display_active_in = 1'b1;
      bus.layer_valid = v; bus.layer_rgb = rgb;
      for (int i = 0; i < n; i++) step();
   endtask
   task automatic drive_frame(input bit da_off, input int wr_pos, input bit rnd_wr);
      int x, y;
      for (int p = 0; p < LINE*LINES; p++) begin
         x = p % LINE;
         y = p / LINE;
         bus.hsync_in          = x >= 2;
         bus.vsync_in          = y != 0;
         bus.display_active_in = !da_off && x >= 4 && y >= 1;
         bus.hcount            = 10'(x);
         bus.vcount            = 10'(y);
         bus.layer_rgb         = (NL*PW)'($urandom);
         bus.layer_valid       = NL'($urandom);
         bus.cfg_wr            = (p == wr_pos) || (rnd_wr && $urandom_range(63) == 0);
         bus.cfg_enable        = NL'($urandom);
         bus.cfg_backdrop      = PW'($urandom);
         step();
      end
      bus.cfg_wr = 1'b0;
   endtask
   initial begin
      int lat, fc0;
      bus.hsync_in = 1'b1; bus.vsync_in = 1'b1; bus.display_active_in = 1'b0;
      bus.hcount = '0; bus.vcount = '0; bus.layer_rgb = '0; bus.layer_valid = '0;
      bus.cfg_wr = 1'b0; bus.cfg_enable = '0; bus.cfg_backdrop = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h0);
      check("rst_hsync", 32'(bus.hsync), 32'h1);
      check("rst_vsync", 32'(bus.vsync), 32'h1);
      check("rst_frame_start", 32'(bus.frame_start), 32'h0);
      check("rst_frame_count", 32'(bus.frame_count), 32'h0);
      check("rst_pending", 32'(bus.cfg_pending), 32'h0);
      @(negedge clk) reset_n = 1'b1;
      hold(2'b00, '0, 4);
      check("empty_backdrop", 32'({bus.red, bus.green, bus.blue}), 32'h0);
      bus.hsync_in = 1'b0;
      lat = 0;
      while (bus.hsync !== 1'b0 && lat < 10) begin
         step();
         bus.hsync_in = 1'b1;
         lat++;
      end
      check("hsync_latency", 32'(lat), 32'd3);
      hold(2'b00, '0, 3);
      bus.cfg_wr = 1'b1; bus.cfg_enable = 2'b11; bus.cfg_backdrop = '0;
      step();
      bus.cfg_wr = 1'b0;
      drive_frame(1'b0, -1, 1'b0);
      hold(2'b11, {12'hF00, 12'h0F0}, 3);
      check("prio_top", 32'({bus.red, bus.green, bus.blue}), 32'hF00);
      hold(2'b01, {12'hF00, 12'h0F0}, 1);
      check("prio_low", 32'({bus.red, bus.green, bus.blue}), 32'h0F0);
      bus.cfg_wr = 1'b1; bus.cfg_enable = 2'b01; bus.cfg_backdrop = 12'h00F;
      step();
      bus.cfg_wr = 1'b0;
      check("pending_set", 32'(bus.cfg_pending), 32'h1);
      hold(2'b00, '0, 2);
      check("no_midframe_change", 32'({bus.red, bus.green, bus.blue}), 32'h0);
      drive_frame(1'b0, -1, 1'b0);
      hold(2'b00, '0, 3);
      check("backdrop_committed", 32'({bus.red, bus.green, bus.blue}), 32'h00F);
      check("pending_clear", 32'(bus.cfg_pending), 32'h0);
      bus.cfg_wr = 1'b1; bus.cfg_enable = 2'b10; bus.cfg_backdrop = 12'h0AA;
      step();
      bus.cfg_wr = 1'b0;
      drive_frame(1'b0, PD, 1'b0);
      check("pending_after_bnd_wr", 32'(bus.cfg_pending), 32'h1);
      hold(2'b00, '0, 3);
      check("first_write_active", 32'({bus.red, bus.green, bus.blue}), 32'h0AA);
      drive_frame(1'b0, -1, 1'b0);
      check("pending_after_commit", 32'(bus.cfg_pending), 32'h0);
      fc0 = int'(bus.frame_count);
      for (int f = 0; f < 256; f++) drive_frame($urandom_range(3) == 0, ($urandom_range(7) == 0) ? PD : -1, 1'b1);
      check("frame_count_wrap", 32'(bus.frame_count), 32'(fc0));
      for (int f = 0; f < 4; f++) drive_frame(1'b1, -1, 1'b1);
      hold(2'b00, '0, 3);
      bus.cfg_wr = 1'b1; bus.cfg_enable = 2'b10; bus.cfg_backdrop = 12'h123;
      step();
      bus.cfg_wr = 1'b0;
      hold(2'b11, {12'hF00, 12'h0F0}, 2);
      #5 reset_n = 1'b0;
      #1;
      check("async_rst_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h0);
      check("async_rst_hsync", 32'(bus.hsync), 32'h1);
      check("async_rst_vsync", 32'(bus.vsync), 32'h1);
      check("async_rst_pending", 32'(bus.cfg_pending), 32'h0);
      check("async_rst_count", 32'(bus.frame_count), 32'h0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      drive_frame(1'b0, -1, 1'b0);
      hold(2'b01, {12'hF00, 12'h0F0}, 3);
      check("rst_enable_l0", 32'({bus.red, bus.green, bus.blue}), 32'h0F0);
      hold(2'b10, {12'hF00, 12'h0F0}, 1);
      check("rst_enable_l1_off", 32'({bus.red, bus.green, bus.blue}), 32'h0);
      drive_frame(1'b0, -1, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/video_layer_compositor.md
Name: video_layer_compositor

Overview:
Parametrised successor to the card's fixed text/graphics RGB output selection. Composites NUM_LAYERS renderer outputs by priority with per-layer enables and a backdrop colour, delays hsync/vsync/display_active to match renderer latency, and applies configuration changes only at frame boundaries. Sits between the renderers and the VGA DAC pins, fed by vga_timing.

Parameters:
NUM_LAYERS, 2, number of renderer inputs; layer NUM_LAYERS-1 has highest priority
COLOR_W, 4, bits per colour channel (pixel word is 3*COLOR_W, {R,G,B})
PIPE_DEPTH, 2, renderer latency in cycles; timing inputs delayed this much (0 allowed)
SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync asserted low
FRAME_CNT_W, 8, width of frame counter
RESET_ENABLE, 1, layer-enable mask after reset (bit 0 only by default)

Ports:
clk_25mhz  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
hsync_in  in  1  raw hsync from timing generator
vsync_in  in  1  raw vsync from timing generator
display_active_in  in  1  raw active-video flag
hcount  in  10  raw horizontal count (debug feature only)
vcount  in  10  raw vertical count (debug feature only)
layer_rgb  in  NUM_LAYERS*3*COLOR_W  renderer pixels, layer i at [i*3*COLOR_W +: 3*COLOR_W]
layer_valid  in  NUM_LAYERS  per-layer opaque flag, aligned with layer_rgb
cfg_wr  in  1  one-cycle strobe, load shadow config
cfg_enable  in  NUM_LAYERS  requested layer-enable mask
cfg_backdrop  in  3*COLOR_W  requested backdrop colour
cfg_pending  out  1  shadow config awaiting commit
red / green / blue  out  COLOR_W each  registered colour outputs
hsync / vsync  out  1  aligned, registered syncs
frame_start  out  1  one-cycle pulse at commit point
frame_count  out  FRAME_CNT_W  wrapping frame counter

Behaviour:
- Reset (async): red/green/blue=0, hsync/vsync at inactive level, delay line filled with inactive sync/display_active=0, frame_start=0, frame_count=0, cfg_pending=0, active enable=RESET_ENABLE, active backdrop=0, shadow=active.
- Alignment: timing inputs pass through PIPE_DEPTH-stage shift register -> aligned timing (A_*). layer_rgb/layer_valid are already aligned with A_*.
- Compositing (combinational, then one register): if !A_display_active -> 0; else highest i with layer_valid[i] & enable[i] -> layer_rgb[i]; none -> backdrop.
- Total latency: hsync/vsync/display_active_in to outputs = PIPE_DEPTH+1; layer_rgb to RGB = 1.
- Frame boundary: first cycle A_vsync goes inactive->active level. On that cycle: frame_count+1 (wraps at 2^FRAME_CNT_W), frame_start=1 next cycle (coincident with output vsync edge), and if cfg_pending: active<=shadow, cfg_pending<=0.
- cfg_wr: shadow<=cfg_enable/cfg_backdrop, cfg_pending<=1. Repeated writes before commit: last wins.
- cfg_wr on boundary cycle: active takes previous shadow; new values load shadow; cfg_pending stays 1 (commit next frame).
- Config never changes mid-frame; enable=0 mask -> all active pixels backdrop.
- Reset mid-frame: outputs return to reset values immediately; pending write discarded.

Optional Feature:
VGA_BORDER_DEBUG_EN: when defined, hcount/vcount go through the same delay line; active pixels with A_hcount==0, ==639, A_vcount==0 or ==479 output all-ones colour, overriding layers and backdrop. When undefined, hcount/vcount are unused and no extra delay registers exist.

Test Plan:
- Reset then display_active_in=1, NUM_LAYERS=2, layer_valid=00 -> RGB=0 (backdrop 0), layer 0 enabled by default; hsync toggle appears on output after exactly 3 cycles (PIPE_DEPTH=2).
- layer_valid=11, layer1=0xF00, layer0=0x0F0, enable=11 committed -> RGB=0xF00; clear layer_valid[1] -> 0x0F0 one cycle later.
- cfg_wr enable=01, backdrop=0x00F mid-frame -> cfg_pending=1, RGB unchanged until vsync edge; at boundary frame_start pulses, cfg_pending=0, empty pixels become 0x00F.
- cfg_wr on exact boundary cycle with pending write A then B -> A active this frame, B applied at next boundary, cfg_pending 1 through frame.
- display_active_in=0 with layer_valid=11 -> RGB=0; 256 frame boundaries -> frame_count wraps 255->0.
- Assert reset_n low mid-line with cfg_pending=1 -> outputs 0/inactive same cycle asynchronously, cfg_pending=0, enable=RESET_ENABLE after release.
